ir_decode_stage: RTL

- Parametrised, pipelined successor to the combinational instruction register/decoder. It sits between fetch and the register-file/execute stage.
- Accepts {pc, inst} over a valid/ready handshake and decodes opcode, register fields, 16-bit immediate, mode and jump target.
- Registers the decoded result and carries a 1-entry skid buffer, so fetch can stream at full rate while execute back-pressures.
- Adds type flags, illegal-opcode detection, flush and a retired-instruction counter.

---
 rtl/ir_decode_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ir_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ir_decode_stage
//  Purpose  : Pipelined instruction decoder with a valid/ready handshake,
//             1-entry skid buffer, flush and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module ir_decode_stage #(
    parameter int XLEN         = 32,
    parameter int REG_W        = 4,
    parameter int SIGN_EXT_IMM = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rs2,
    output logic [XLEN-1:0]   imm_ext,
    output logic [1:0]        mode,
    output logic [XLEN-1:0]   jmp_target,
    output logic              is_r,
    output logic              is_i,
    output logic              is_j,
    output logic              is_s,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef struct packed {
        logic [5:0]        opcode;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [XLEN-1:0]   imm_ext;
        logic [1:0]        mode;
        logic [XLEN-1:0]   jmp_target;
        logic              is_r;
        logic              is_i;
        logic              is_j;
        logic              is_s;
        logic              illegal;
    } bundle_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [5:0]      w_op;
    logic            w_cls_r;
    logic            w_cls_i;
    logic            w_cls_j;
    logic            w_cls_s;
    logic [XLEN-1:0] w_imm;
    bundle_t         w_dec;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_unused_pc;

    bundle_t         r_out;
    bundle_t         r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;
    logic [CNT_W-1:0] r_retired;

    assign w_op    = inst[31:26];
    assign w_cls_r = (w_op[5:2] == 4'b0000) && (w_op != 6'b000011);
    assign w_cls_i = (w_op[5:2] == 4'b0001) || (w_op[5:2] == 4'b0010) ||
                     (w_op == 6'b000011);
    assign w_cls_j = (w_op == 6'b001100) || (w_op == 6'b001101);
    assign w_cls_s = (w_op == 6'b001111) || (w_op == 6'b010000);
    assign w_imm   = {{(XLEN-16){(SIGN_EXT_IMM != 0) && inst[17]}}, inst[17:2]};
    // Only the upper PC bits reach the jump target; the rest are never needed.
    assign w_unused_pc = &{1'b0, pc[25:0]};

    // Fields a class does not use stay zero so nothing stale leaks downstream.
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_op;
        if (w_cls_r) begin
            w_dec.rd[3:0]  = inst[25:22];
            w_dec.rs1[3:0] = inst[21:18];
            w_dec.rs2[3:0] = inst[17:14];
            w_dec.is_r     = 1'b1;
        end else if (w_cls_i) begin
            w_dec.rd[3:0]  = inst[25:22];
            w_dec.rs1[3:0] = inst[21:18];
            w_dec.imm_ext  = w_imm;
            w_dec.mode     = inst[1:0];
            w_dec.is_i     = 1'b1;
        end else if (w_cls_j) begin
            w_dec.jmp_target = {pc[XLEN-1:26], inst[25:0]};
            w_dec.is_j       = 1'b1;
        end else if (w_cls_s) begin
            w_dec.rd[3:0] = inst[25:22];
            w_dec.is_s    = 1'b1;
        end else begin
            w_dec.illegal = 1'b1;
        end
    end

    assign in_ready   = !r_skid_valid;
    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_out_fire = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_retired    <= '0;
        end else begin
            if (w_out_fire && (r_retired != c_cnt_max)) begin
                r_retired <= r_retired + 1'b1;
            end
            if (flush) begin
                r_out        <= '0;
                r_skid       <= '0;
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_out_valid || w_out_fire) begin
                // Output slot frees up: the skid entry is older, so it wins.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign opcode     = r_out.opcode;
    assign rd         = r_out.rd;
    assign rs1        = r_out.rs1;
    assign rs2        = r_out.rs2;
    assign imm_ext    = r_out.imm_ext;
    assign mode       = r_out.mode;
    assign jmp_target = r_out.jmp_target;
    assign is_r       = r_out.is_r;
    assign is_i       = r_out.is_i;
    assign is_j       = r_out.is_j;
    assign is_s       = r_out.is_s;
    assign illegal    = r_out.illegal;
    assign retired    = r_retired;

endmodule
`default_nettype wire
